// File: rtl/gshare_pkg.sv
// Shared types and counter helpers for the gshare direction predictor.
package gshare_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Counters are handled at a fixed 4-bit width here; callers resize to CNT_W (2..4).
  function automatic logic [3:0] init_cnt(input int cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

  function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic taken,
                                          input int cnt_w);
    logic [3:0] max_v;
    max_v = 4'((1 << cnt_w) - 1);
    if (taken) return (cnt == max_v) ? cnt : cnt + 4'd1;
    else       return (cnt == 4'd0)  ? cnt : cnt - 4'd1;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: one registered read-first port for prediction, one write port,
// and a combinational read for the update read-modify-write. Peek port under GSHARE_SPEC_HIST_EN.
module gshare_pht #(
  parameter int IDX_W = 12,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [CNT_W-1:0] o_rdata,
  input  logic [IDX_W-1:0] i_uaddr,
  output logic [CNT_W-1:0] o_udata
`ifdef GSHARE_SPEC_HIST_EN
  ,
  output logic             o_peek_msb
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CNT_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_rdata;

  // NOTE: the array has no reset; clearing it is the job of the init sweep, so it maps to RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // NOTE: non-blocking assignments make this read see the pre-write value on a same-address write.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
  assign o_udata = r_mem[i_uaddr];
`ifdef GSHARE_SPEC_HIST_EN
  assign o_peek_msb = r_mem[i_raddr][CNT_W-1];
`endif

endmodule

// File: rtl/gshare_predictor.sv
// gshare branch direction predictor with init sweep and 1-cycle prediction latency.
// Define GSHARE_SPEC_HIST_EN for speculative history with mispredict repair.
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int IDX_W  = 12,
  parameter int HIST_W = 12,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_rsp_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispredict
);

  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(init_cnt(CNT_W));

  state_e            r_state, w_state_next;
  logic [IDX_W-1:0]  r_sweep;
  logic [HIST_W-1:0] r_ghr, w_ghr_next;
  logic              r_rsp_valid;
  logic [IDX_W-1:0]  r_pred_idx;
  logic [HIST_W-1:0] r_pred_hist;

  logic              w_run, w_accept, w_upd;
  logic [IDX_W-1:0]  w_pred_idx;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [CNT_W-1:0]  w_wdata, w_upd_cnt, w_rdata;
`ifdef GSHARE_SPEC_HIST_EN
  logic              w_peek_msb;
`endif

  assign w_run      = (r_state == ST_RUN);
  assign w_accept   = w_run && pred_valid;
  assign w_upd      = w_run && upd_valid;
  assign w_pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_waddr      = r_sweep;
    w_wdata      = INIT_CNT;
    case (r_state)
      ST_INIT: begin
        w_we = 1'b1;
        if (&r_sweep) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (upd_valid) begin
          w_we    = 1'b1;
          w_waddr = upd_idx;
          w_wdata = CNT_W'(cnt_next(4'(w_upd_cnt), upd_taken, CNT_W));
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  always_comb begin
    w_ghr_next = r_ghr;
`ifdef GSHARE_SPEC_HIST_EN
    if (w_accept)                   w_ghr_next = HIST_W'({r_ghr, w_peek_msb});
    if (w_upd && upd_mispredict)    w_ghr_next = HIST_W'({upd_hist, upd_taken});
`else
    if (w_upd)                      w_ghr_next = HIST_W'({r_ghr, upd_taken});
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_sweep     <= '0;
      r_ghr       <= '0;
      r_rsp_valid <= 1'b0;
      r_pred_idx  <= '0;
      r_pred_hist <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ghr       <= w_ghr_next;
      r_rsp_valid <= w_accept;
      if (r_state == ST_INIT) r_sweep <= r_sweep + 1'b1;
      if (w_accept) begin
        r_pred_idx  <= w_pred_idx;
        r_pred_hist <= r_ghr;
      end
    end
  end

  gshare_pht #(
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) u_pht (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_re      (w_accept),
    .i_raddr   (w_pred_idx),
    .o_rdata   (w_rdata),
    .i_uaddr   (upd_idx),
    .o_udata   (w_upd_cnt)
`ifdef GSHARE_SPEC_HIST_EN
    ,
    .o_peek_msb(w_peek_msb)
`endif
  );

  assign ready          = w_run;
  assign pred_rsp_valid = r_rsp_valid;
  assign pred_taken     = w_rdata[CNT_W-1];
  assign pred_idx       = r_pred_idx;
  assign pred_hist      = r_pred_hist;

endmodule
